// File: rtl/maindec_fsm.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/
// execute/memory/writeback and drives every mux select and write enable.
module maindec_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic             zero,
    output logic             pc_write,
    output logic             pc_en,
    output logic             branch,
    output logic             ir_write,
    output logic             mem_write,
    output logic             reg_write,
    output logic             iord,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_op,
    output logic [3:0]       state,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             illegal_op
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_RTYPEWB = 4'd7;
    localparam logic [3:0] S_BEQEX   = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JEX     = 4'd11;
    localparam logic [3:0] S_RST     = 4'hF;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
    logic             illegal_op_q, illegal_op_d;

    // Next-state logic; op is only meaningful in DECODE and MEMADR.
    always_comb begin
        state_d      = S_FETCH;
        illegal_op_d = illegal_op_q;
        case (state_q)
            S_RST:   state_d = S_FETCH;
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default: begin
                        state_d      = S_FETCH;
                        illegal_op_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_MEMWB, S_MEMWR, S_RTYPEWB, S_BEQEX, S_ADDIWB, S_JEX:
                state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // Moore control decode; every signal defaults low, which also covers RST.
    always_comb begin
        pc_write   = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        iord       = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_op     = 2'b00;
        retire     = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 2'b01;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                retire    = 1'b1;
            end
            S_RTYPEEX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RTYPEWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
            end
            S_BEQEX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch    = 1'b1;
                retire    = 1'b1;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_JEX: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                retire   = 1'b1;
            end
            default: ;
        endcase
    end

    assign retired_cnt_d = retire ? retired_cnt_q + 1'b1 : retired_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RST;
            retired_cnt_q <= '0;
            illegal_op_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            retired_cnt_q <= retired_cnt_d;
            illegal_op_q  <= illegal_op_d;
        end
    end

    // pc_en is the only output that looks at an input combinationally.
    assign pc_en       = pc_write | (branch & zero);
    assign state       = state_q;
    assign retired_cnt = retired_cnt_q;
    assign illegal_op  = illegal_op_q;

endmodule

// File: tb/tb_maindec_fsm.sv
// Directed, table-driven bench for maindec_fsm; a narrow counter exercises wrap.
module tb_maindec_fsm;

  localparam int CW = 3;

  logic          clk;
  logic          rst_n;
  logic [5:0]    op;
  logic          zero;
  logic          pc_write, pc_en, branch, ir_write, mem_write, reg_write;
  logic          iord, mem_to_reg, reg_dst, alu_src_a, retire, illegal_op;
  logic [1:0]    alu_src_b, pc_src, alu_op;
  logic [3:0]    state;
  logic [CW-1:0] retired_cnt;

  maindec_fsm #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero),
    .pc_write(pc_write), .pc_en(pc_en), .branch(branch), .ir_write(ir_write),
    .mem_write(mem_write), .reg_write(reg_write), .iord(iord),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op), .state(state),
    .retire(retire), .retired_cnt(retired_cnt), .illegal_op(illegal_op)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write,pc_en,branch,ir_write,mem_write,reg_write,iord,mem_to_reg,
  //  reg_dst,alu_src_a,alu_src_b[1:0],pc_src[1:0],alu_op[1:0],retire}
  logic [16:0] act_ctrl;
  assign act_ctrl = {pc_write, pc_en, branch, ir_write, mem_write, reg_write,
                     iord, mem_to_reg, reg_dst, alu_src_a, alu_src_b, pc_src,
                     alu_op, retire};

  localparam logic [16:0] C_NONE   = 17'b0;
  localparam logic [16:0] C_FETCH  = 17'b1101000000_01_00_00_0;
  localparam logic [16:0] C_DECODE = 17'b0000000000_11_00_00_0;
  localparam logic [16:0] C_ADR    = 17'b0000000001_10_00_00_0;
  localparam logic [16:0] C_MEMRD  = 17'b0000001000_00_00_00_0;
  localparam logic [16:0] C_MEMWB  = 17'b0000010100_00_00_00_1;
  localparam logic [16:0] C_MEMWR  = 17'b0000101000_00_00_00_1;
  localparam logic [16:0] C_REX    = 17'b0000000001_00_00_10_0;
  localparam logic [16:0] C_RWB    = 17'b0000010010_00_00_00_1;
  localparam logic [16:0] C_BEQ_T  = 17'b0110000001_00_01_01_1;
  localparam logic [16:0] C_BEQ_N  = 17'b0010000001_00_01_01_1;
  localparam logic [16:0] C_AWB    = 17'b0000010000_00_00_00_1;
  localparam logic [16:0] C_JEX    = 17'b1100000000_00_10_00_1;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct {
    logic [5:0]    op;
    logic          zero;
    logic [3:0]    st;
    logic [16:0]   ctrl;
    logic [CW-1:0] cnt;
    logic          ill;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;

  task automatic add(input logic [5:0] o, input logic z, input logic [3:0] s,
                     input logic [16:0] c, input int n, input logic il);
    vec_t v;
    v.op = o; v.zero = z; v.st = s; v.ctrl = c; v.cnt = n[CW-1:0]; v.ill = il;
    vecs.push_back(v);
  endtask

  // scoreboard comparison
  task automatic chk(input string name, input int idx,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp)
      $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, got, exp);
    else
      passed++;
  endtask

  task automatic chk_all(input string tag, input int idx, input logic [3:0] s,
                         input logic [16:0] c, input int n, input logic il);
    chk({tag, "_state"}, idx, 32'(state), 32'(s));
    chk({tag, "_ctrl"}, idx, 32'(act_ctrl), 32'(c));
    chk({tag, "_cnt"}, idx, 32'(retired_cnt), 32'(n[CW-1:0]));
    chk({tag, "_ill"}, idx, 32'(illegal_op), 32'(il));
  endtask

  initial begin
    rst_n = 1'b0;
    op    = 6'b0;
    zero  = 1'b0;

    // lw: 5 cycles
    add(LW,   1, 4'd0,  C_FETCH,  0, 0);
    add(LW,   0, 4'd1,  C_DECODE, 0, 0);
    add(LW,   0, 4'd2,  C_ADR,    0, 0);
    add(LW,   0, 4'd3,  C_MEMRD,  0, 0);
    add(LW,   0, 4'd4,  C_MEMWB,  0, 0);
    // sw: 4 cycles
    add(SW,   0, 4'd0,  C_FETCH,  1, 0);
    add(SW,   0, 4'd1,  C_DECODE, 1, 0);
    add(SW,   0, 4'd2,  C_ADR,    1, 0);
    add(SW,   0, 4'd5,  C_MEMWR,  1, 0);
    // beq taken / not taken
    add(BEQ,  0, 4'd0,  C_FETCH,  2, 0);
    add(BEQ,  1, 4'd1,  C_DECODE, 2, 0);
    add(BEQ,  1, 4'd8,  C_BEQ_T,  2, 0);
    add(BEQ,  0, 4'd0,  C_FETCH,  3, 0);
    add(BEQ,  0, 4'd1,  C_DECODE, 3, 0);
    add(BEQ,  0, 4'd8,  C_BEQ_N,  3, 0);
    // R-type, addi, j
    add(RT,   0, 4'd0,  C_FETCH,  4, 0);
    add(RT,   0, 4'd1,  C_DECODE, 4, 0);
    add(RT,   0, 4'd6,  C_REX,    4, 0);
    add(RT,   0, 4'd7,  C_RWB,    4, 0);
    add(ADDI, 0, 4'd0,  C_FETCH,  5, 0);
    add(ADDI, 0, 4'd1,  C_DECODE, 5, 0);
    add(ADDI, 0, 4'd9,  C_ADR,    5, 0);
    add(ADDI, 0, 4'd10, C_AWB,    5, 0);
    add(J,    0, 4'd0,  C_FETCH,  6, 0);
    add(J,    0, 4'd1,  C_DECODE, 6, 0);
    add(J,    0, 4'd11, C_JEX,    6, 0);
    // illegal opcode: 2 cycles, no retire, sticky flag
    add(BAD,  0, 4'd0,  C_FETCH,  7, 0);
    add(BAD,  0, 4'd1,  C_DECODE, 7, 0);
    add(LW,   0, 4'd0,  C_FETCH,  7, 1);
    add(LW,   0, 4'd1,  C_DECODE, 7, 1);
    add(LW,   0, 4'd2,  C_ADR,    7, 1);
    add(LW,   0, 4'd3,  C_MEMRD,  7, 1);
    add(LW,   0, 4'd4,  C_MEMWB,  7, 1);
    // eighth retire wraps the 3-bit counter to 0
    add(J,    0, 4'd0,  C_FETCH,  0, 1);
    add(J,    0, 4'd1,  C_DECODE, 0, 1);
    add(J,    0, 4'd11, C_JEX,    0, 1);
    // lw that will be cut short by reset in MEMRD
    add(LW,   0, 4'd0,  C_FETCH,  1, 1);
    add(LW,   0, 4'd1,  C_DECODE, 1, 1);
    add(LW,   0, 4'd2,  C_ADR,    1, 1);
    add(LW,   0, 4'd3,  C_MEMRD,  1, 1);

    // reset held low for 3 cycles: RST with all outputs low
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      zero = (i == 1);
      #1;
      chk_all("rst", i, 4'hF, C_NONE, 0, 0);
    end
    rst_n = 1'b1;

    // driver: apply each vector in the low clock phase, sample 1ns later
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      op   = vecs[i].op;
      zero = vecs[i].zero;
      #1;
      chk_all("vec", i, vecs[i].st, vecs[i].ctrl, int'(vecs[i].cnt), vecs[i].ill);
    end

    // asynchronous reset mid-MEMRD: immediate RST, no writeback ever
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 4'hF, C_NONE, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk("rst_hold_reg_write", i, 32'(reg_write), 32'd0);
      chk("rst_hold_state", i, 32'(state), 32'hF);
    end
    rst_n = 1'b1;
    @(negedge clk);
    op = ADDI;
    #1;
    chk_all("restart", 0, 4'd0, C_FETCH, 0, 0);
    @(negedge clk);
    #1;
    chk_all("restart", 1, 4'd1, C_DECODE, 0, 0);
    @(negedge clk);
    #1;
    chk_all("restart", 2, 4'd9, C_ADR, 0, 0);
    @(negedge clk);
    #1;
    chk_all("restart", 3, 4'd10, C_AWB, 0, 0);
    @(negedge clk);
    #1;
    chk_all("restart", 4, 4'd0, C_FETCH, 1, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
